// File: rtl/count_monitor.sv
// -----------------------------------------------------------------------------
// count_monitor
//
// Integrity checker for a free-running up-counter interface (en, count).
// Every cycle it predicts the next count from the previous sample:
//    expected = prev + prev_en  (mod 2^WIDTH)
// This covers both hold (en low) and wrap-around. After LOCK_CNT consecutive
// correct samples the monitor locks (TRACK). Once locked, each mismatch pulses
// `error` and bumps a saturating error counter. ERR_LIMIT consecutive
// mismatches move it to a sticky FAULT state that only rst/clr can leave.
//
// Parameters
//    WIDTH     : width of the monitored count
//    LOCK_CNT  : consecutive matches needed to lock        (1..15)
//    ERR_LIMIT : consecutive mismatches in TRACK -> FAULT  (1..15)
//    ECW       : width of the error counter
//
// Ports
//    clk       : system clock, rising edge
//    rst       : synchronous active-high reset
//    en        : counter enable (same net that drives the counter)
//    count     : counter output being monitored
//    clr       : synchronous clear, behaves as rst (rst has priority)
//    locked    : high while in TRACK
//    error     : one-cycle pulse per mismatch detected in TRACK
//    fault     : high while in FAULT
//    err_count : saturating count of mismatches detected in TRACK
//    expected  : prediction for the current cycle's count
// -----------------------------------------------------------------------------
module count_monitor #(
   parameter int unsigned WIDTH     = 5,
   parameter int unsigned LOCK_CNT  = 4,
   parameter int unsigned ERR_LIMIT = 3,
   parameter int unsigned ECW       = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] count,
   input  logic             clr,
   output logic             locked,
   output logic             error,
   output logic             fault,
   output logic [ECW-1:0]   err_count,
   output logic [WIDTH-1:0] expected
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SYNC,
      S_TRACK,
      S_FAULT
   } state_t;

   // Run counters are 4 bits; one extra bit on the increment makes the
   // "would reach the limit" compare free of wrap-around.
   localparam logic [4:0] LOCK_V = 5'(LOCK_CNT);
   localparam logic [4:0] ERR_V  = 5'(ERR_LIMIT);

   state_t           state;
   state_t           state_n;
   logic [WIDTH-1:0] prev;
   logic             prev_en;
   logic [3:0]       good_run;
   logic [3:0]       good_run_n;
   logic [3:0]       bad_run;
   logic [3:0]       bad_run_n;
   logic [ECW-1:0]   err_count_n;
   logic             error_n;
   logic [4:0]       good_inc;
   logic [4:0]       bad_inc;
   logic             match;

   // ---------------------------------------------------------------------------
   // State and data registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         state     <= S_IDLE;
         prev      <= '0;
         prev_en   <= 1'b0;
         good_run  <= '0;
         bad_run   <= '0;
         err_count <= '0;
         error     <= 1'b0;
      end else begin
         state     <= state_n;
         prev      <= count;
         prev_en   <= en;
         good_run  <= good_run_n;
         bad_run   <= bad_run_n;
         err_count <= err_count_n;
         error     <= error_n;
      end
   end

   // ---------------------------------------------------------------------------
   // Prediction. prev/prev_en are zero throughout IDLE, so expected reads 0
   // there without special-casing.
   // ---------------------------------------------------------------------------
   always_comb begin
      expected = prev + {{(WIDTH-1){1'b0}}, prev_en};
      match    = (count == expected);
   end

   // ---------------------------------------------------------------------------
   // Next-state and run/error bookkeeping
   // ---------------------------------------------------------------------------
   always_comb begin
      state_n     = state;
      good_run_n  = good_run;
      bad_run_n   = bad_run;
      err_count_n = err_count;
      error_n     = 1'b0;
      good_inc    = {1'b0, good_run} + 5'd1;
      bad_inc     = {1'b0, bad_run} + 5'd1;

      unique case (state)
         S_IDLE: begin
            // One capture cycle; no compare because prev is not yet valid.
            state_n = S_SYNC;
         end

         S_SYNC: begin
            if (match) begin
               if (good_inc >= LOCK_V) begin
                  state_n    = S_TRACK;
                  good_run_n = '0;
               end else begin
                  good_run_n = good_inc[3:0];
               end
            end else begin
               good_run_n = '0;
            end
         end

         S_TRACK: begin
            if (match) begin
               bad_run_n = '0;
            end else begin
               error_n = 1'b1;
               if (err_count != '1) begin
                  err_count_n = err_count + ECW'(1);
               end
               // The final pulse and count increment still occur on the
               // transition into FAULT.
               bad_run_n = bad_inc[3:0];
               if (bad_inc >= ERR_V) begin
                  state_n = S_FAULT;
               end
            end
         end

         S_FAULT: begin
            // Sticky; only rst/clr leave. Counters frozen.
            state_n = S_FAULT;
         end

         default: begin
            state_n = S_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Status outputs decoded from the registered state
   // ---------------------------------------------------------------------------
   always_comb begin
      locked = (state == S_TRACK);
      fault  = (state == S_FAULT);
   end

endmodule

// File: tb/tb_count_monitor.sv
// -----------------------------------------------------------------------------
// tb_count_monitor
//
// Self-checking bench for count_monitor: a directed vector table with fixed
// expected outputs, hand-written multi-cycle sequences (wrap, SYNC noise,
// error-counter saturation) and a randomized phase checked against a
// behavioural reference model.
// -----------------------------------------------------------------------------
module tb_count_monitor;

   localparam int W  = 5;
   localparam int LC = 4;
   localparam int EL = 3;
   localparam int EC = 8;
   localparam int MOD = 32;
   localparam int ECMAX = 255;

   logic         clk = 1'b0;
   logic         rst;
   logic         clr;
   logic         en;
   logic [W-1:0] count;
   logic         locked;
   logic         error;
   logic         fault;
   logic [EC-1:0] err_count;
   logic [W-1:0] expected;

   count_monitor #(
      .WIDTH     (W),
      .LOCK_CNT  (LC),
      .ERR_LIMIT (EL),
      .ECW       (EC)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .count     (count),
      .clr       (clr),
      .locked    (locked),
      .error     (error),
      .fault     (fault),
      .err_count (err_count),
      .expected  (expected)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // ---------------------------------------------------------------------------
   // Reference model: history-based view of the rules (last sample, streak
   // lengths, lock/fault flags, unbounded error total).
   // ---------------------------------------------------------------------------
   int m_last, m_last_en, m_started, m_streak, m_miss;
   int m_locked, m_fault, m_errs, m_pulse;

   function automatic void model_reset();
      m_last = 0; m_last_en = 0; m_started = 0; m_streak = 0; m_miss = 0;
      m_locked = 0; m_fault = 0; m_errs = 0; m_pulse = 0;
   endfunction

   function automatic void model_step();
      int pred;
      if (rst || clr) begin
         model_reset();
      end else begin
         pred    = (m_last + m_last_en) % MOD;
         m_pulse = 0;
         if (m_started != 0 && m_fault == 0) begin
            if (m_locked != 0) begin
               if (int'(count) != pred) begin
                  m_pulse = 1;
                  m_errs++;
                  m_miss++;
                  if (m_miss >= EL) begin
                     m_fault  = 1;
                     m_locked = 0;
                  end
               end else begin
                  m_miss = 0;
               end
            end else begin
               if (int'(count) == pred) begin
                  m_streak++;
                  if (m_streak >= LC) begin
                     m_locked = 1;
                     m_streak = 0;
                  end
               end else begin
                  m_streak = 0;
               end
            end
         end
         m_started = 1;
         m_last    = int'(count);
         m_last_en = int'(en);
      end
   endfunction

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic r, input logic c, input logic e, input int v);
      rst   = r;
      clr   = c;
      en    = e;
      count = W'(v);
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic check_model(input string tag);
      check({tag, "_locked"},    int'(locked),    m_locked);
      check({tag, "_error"},     int'(error),     m_pulse);
      check({tag, "_fault"},     int'(fault),     m_fault);
      check({tag, "_err_count"}, int'(err_count), (m_errs > ECMAX) ? ECMAX : m_errs);
      check({tag, "_expected"},  int'(expected),  (m_last + m_last_en) % MOD);
   endtask

   task automatic step(input string tag, input logic r, input logic c,
                       input logic e, input int v);
      drive(r, c, e, v);
      check_model(tag);
   endtask

   // ---------------------------------------------------------------------------
   // Directed vectors: inputs applied before the edge, outputs after it.
   // ---------------------------------------------------------------------------
   typedef struct {
      logic         rst;
      logic         clr;
      logic         en;
      int           cnt;
      logic         lk;
      logic         er;
      logic         ft;
      int           ec;
      int           ex;
   } vec_t;

   localparam int NV = 28;
   vec_t vecs[NV];

   initial begin
      int cur;
      int v;
      logic e;

      rst = 1'b1; clr = 1'b0; en = 1'b0; count = '0;
      model_reset();

      //              rst   clr   en   cnt  lk    er    ft    ec ex
      vecs[0]  = '{1'b1, 1'b0, 1'b0,  0, 1'b0, 1'b0, 1'b0, 0,  0};  // reset
      vecs[1]  = '{1'b0, 1'b0, 1'b1,  0, 1'b0, 1'b0, 1'b0, 0,  1};  // IDLE capture
      vecs[2]  = '{1'b0, 1'b0, 1'b1,  1, 1'b0, 1'b0, 1'b0, 0,  2};
      vecs[3]  = '{1'b0, 1'b0, 1'b1,  2, 1'b0, 1'b0, 1'b0, 0,  3};
      vecs[4]  = '{1'b0, 1'b0, 1'b1,  3, 1'b0, 1'b0, 1'b0, 0,  4};
      vecs[5]  = '{1'b0, 1'b0, 1'b1,  4, 1'b1, 1'b0, 1'b0, 0,  5};  // 4th match -> lock
      vecs[6]  = '{1'b0, 1'b0, 1'b1,  5, 1'b1, 1'b0, 1'b0, 0,  6};
      vecs[7]  = '{1'b0, 1'b0, 1'b0,  6, 1'b1, 1'b0, 1'b0, 0,  6};  // en low: hold
      vecs[8]  = '{1'b0, 1'b0, 1'b1,  6, 1'b1, 1'b0, 1'b0, 0,  7};
      vecs[9]  = '{1'b0, 1'b0, 1'b1,  7, 1'b1, 1'b0, 1'b0, 0,  8};
      vecs[10] = '{1'b0, 1'b0, 1'b1,  8, 1'b1, 1'b0, 1'b0, 0,  9};
      vecs[11] = '{1'b0, 1'b0, 1'b1,  9, 1'b1, 1'b0, 1'b0, 0, 10};
      vecs[12] = '{1'b0, 1'b0, 1'b1, 10, 1'b1, 1'b0, 1'b0, 0, 11};
      vecs[13] = '{1'b0, 1'b0, 1'b1, 11, 1'b1, 1'b0, 1'b0, 0, 12};
      vecs[14] = '{1'b0, 1'b0, 1'b1,  7, 1'b1, 1'b1, 1'b0, 1,  8};  // glitch 7 vs 12
      vecs[15] = '{1'b0, 1'b0, 1'b1,  8, 1'b1, 1'b0, 1'b0, 1,  9};  // counter resumes from 7
      vecs[16] = '{1'b0, 1'b0, 1'b1,  9, 1'b1, 1'b0, 1'b0, 1, 10};
      vecs[17] = '{1'b0, 1'b0, 1'b1, 20, 1'b1, 1'b1, 1'b0, 2, 21};  // bad 1
      vecs[18] = '{1'b0, 1'b0, 1'b1,  3, 1'b1, 1'b1, 1'b0, 3,  4};  // bad 2
      vecs[19] = '{1'b0, 1'b0, 1'b1,  0, 1'b0, 1'b1, 1'b1, 4,  1};  // bad 3 -> FAULT
      vecs[20] = '{1'b0, 1'b0, 1'b1, 25, 1'b0, 1'b0, 1'b1, 4, 26};  // no compare in FAULT
      vecs[21] = '{1'b0, 1'b0, 1'b1, 26, 1'b0, 1'b0, 1'b1, 4, 27};
      vecs[22] = '{1'b0, 1'b1, 1'b1,  0, 1'b0, 1'b0, 1'b0, 0,  0};  // clr
      vecs[23] = '{1'b0, 1'b0, 1'b1,  0, 1'b0, 1'b0, 1'b0, 0,  1};  // IDLE capture
      vecs[24] = '{1'b0, 1'b0, 1'b1,  1, 1'b0, 1'b0, 1'b0, 0,  2};
      vecs[25] = '{1'b0, 1'b0, 1'b1,  2, 1'b0, 1'b0, 1'b0, 0,  3};
      vecs[26] = '{1'b0, 1'b0, 1'b1,  3, 1'b0, 1'b0, 1'b0, 0,  4};
      vecs[27] = '{1'b0, 1'b0, 1'b1,  4, 1'b1, 1'b0, 1'b0, 0,  5};  // relocked

      for (int i = 0; i < NV; i++) begin
         drive(vecs[i].rst, vecs[i].clr, vecs[i].en, vecs[i].cnt);
         check($sformatf("vec%0d_locked", i),    int'(locked),    int'(vecs[i].lk));
         check($sformatf("vec%0d_error", i),     int'(error),     int'(vecs[i].er));
         check($sformatf("vec%0d_fault", i),     int'(fault),     int'(vecs[i].ft));
         check($sformatf("vec%0d_err_count", i), int'(err_count), vecs[i].ec);
         check($sformatf("vec%0d_expected", i),  int'(expected),  vecs[i].ex);
      end

      // --- Hold and wrap: en toggling while the count passes 30, 31, 0, 1 ---
      cur = 5;
      for (int i = 0; i < 100; i++) begin
         e = (i % 2 == 1);
         v = cur;
         step("wrap", 1'b0, 1'b0, e, v);
         if (e && v == 30) check("wrap_expected_31", int'(expected), 31);
         if (e && v == 31) begin
            check("wrap_expected_0", int'(expected), 0);
            check("wrap_locked", int'(locked), 1);
         end
         cur = (cur + int'(e)) % MOD;
         if (v == 1 && e) break;
      end
      check("wrap_err_count", int'(err_count), 0);

      // --- SYNC noise: alternating wrong/right never locks, then clean lock ---
      step("noise_rst", 1'b1, 1'b0, 1'b0, 0);
      step("noise_idle", 1'b0, 1'b0, 1'b1, 0);
      cur = 1;
      for (int i = 0; i < 10; i++) begin
         v = (i % 2 == 0) ? (cur + 7) % MOD : cur;
         step("noise", 1'b0, 1'b0, 1'b1, v);
         check("noise_locked", int'(locked), 0);
         check("noise_error", int'(error), 0);
         cur = (cur + 1) % MOD;
      end
      check("noise_err_count", int'(err_count), 0);
      for (int k = 0; k < 4; k++) begin
         step("relock", 1'b0, 1'b0, 1'b1, cur);
         if (k == 2) check("relock_not_yet", int'(locked), 0);
         cur = (cur + 1) % MOD;
      end
      check("relock_locked", int'(locked), 1);

      // --- err_count saturation: isolated mismatches never reach FAULT ---
      for (int i = 0; i < 260; i++) begin
         step("sat_bad", 1'b0, 1'b0, 1'b1, (cur + 3) % MOD);
         step("sat_good", 1'b0, 1'b0, 1'b1, (cur + 4) % MOD);
         cur = (cur + 5) % MOD;
      end
      check("sat_err_count", int'(err_count), ECMAX);
      step("sat_more", 1'b0, 1'b0, 1'b1, (cur + 9) % MOD);
      check("sat_pulse", int'(error), 1);
      check("sat_hold", int'(err_count), ECMAX);
      check("sat_still_locked", int'(locked), 1);

      // --- Randomized traffic against the model ---
      step("rnd_rst", 1'b1, 1'b0, 1'b0, 0);
      cur = $urandom_range(0, MOD - 1);
      for (int i = 0; i < 2000; i++) begin
         logic r;
         logic c;
         r = ($urandom_range(0, 127) == 0);
         c = ($urandom_range(0, 63) == 0);
         e = 1'($urandom_range(0, 1));
         v = ($urandom_range(0, 11) == 0) ? int'($urandom_range(0, MOD - 1)) : cur;
         step("rnd", r, c, e, v);
         cur = (v + int'(e)) % MOD;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
